// File: rtl/univ_shift_reg.sv
// Universal WIDTH-bit shift register: load/NOP complete in one cycle, counted shifts take N cycles plus a done pulse.
// No queueing: start is honoured only in IDLE, and commands arriving while busy are dropped.
module univ_shift_reg #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [CNT_W-1:0] count,
    input  logic             serial_in_l,
    input  logic             serial_in_r,
    input  logic [WIDTH-1:0] parallel_in,
    output logic [WIDTH-1:0] parallel_out,
    output logic             serial_out_l,
    output logic             serial_out_r,
    output logic             busy,
    output logic             done
);

    localparam logic [2:0] OP_NOP  = 3'b000;
    localparam logic [2:0] OP_LOAD = 3'b001;
    localparam logic [2:0] OP_SHL  = 3'b010;
    localparam logic [2:0] OP_SHR  = 3'b011;
    localparam logic [2:0] OP_ROL  = 3'b100;
    localparam logic [2:0] OP_ROR  = 3'b101;
    localparam logic [2:0] OP_ASR  = 3'b110;

    typedef enum logic {IDLE, SHIFT} state_t;

    state_t           state, state_nxt;
    logic [WIDTH-1:0] q, q_nxt;
    logic [CNT_W-1:0] rem, rem_nxt;
    logic [2:0]       op_q, op_nxt;
    logic             done_nxt;

    function automatic logic [WIDTH-1:0] shift1(input logic [WIDTH-1:0] d,
                                                input logic [2:0] o,
                                                input logic sl, input logic sr);
        logic [WIDTH-1:0] r;
        r = d;
        case (o)
            OP_SHL:  r = {d[WIDTH-2:0], sl};
            OP_SHR:  r = {sr, d[WIDTH-1:1]};
            OP_ROL:  r = {d[WIDTH-2:0], d[WIDTH-1]};
            OP_ROR:  r = {d[0], d[WIDTH-1:1]};
            OP_ASR:  r = {d[WIDTH-1], d[WIDTH-1:1]};
            default: r = d;
        endcase
        return r;
    endfunction

    always_comb begin
        state_nxt = state;
        q_nxt     = q;
        rem_nxt   = rem;
        op_nxt    = op_q;
        done_nxt  = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    op_nxt = op;
                    case (op)
                        OP_LOAD: begin
                            q_nxt    = parallel_in;
                            done_nxt = 1'b1;
                        end
                        OP_SHL, OP_SHR, OP_ROL, OP_ROR, OP_ASR: begin
                            // A zero count completes immediately, just like NOP.
                            if (count == '0) begin
                                done_nxt = 1'b1;
                            end else begin
                                rem_nxt   = count;
                                state_nxt = SHIFT;
                            end
                        end
                        default: done_nxt = 1'b1;
                    endcase
                end
            end
            SHIFT: begin
                q_nxt   = shift1(q, op_q, serial_in_l, serial_in_r);
                rem_nxt = rem - CNT_W'(1);
                if (rem == CNT_W'(1)) begin
                    state_nxt = IDLE;
                    done_nxt  = 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            q     <= '0;
            rem   <= '0;
            op_q  <= OP_NOP;
            done  <= 1'b0;
        end else begin
            state <= state_nxt;
            q     <= q_nxt;
            rem   <= rem_nxt;
            op_q  <= op_nxt;
            done  <= done_nxt;
        end
    end

    assign parallel_out = q;
    assign serial_out_l = q[WIDTH-1];
    assign serial_out_r = q[0];
    assign busy         = (state == SHIFT);

endmodule

// File: tb/tb_univ_shift_reg.sv
// Directed-vector bench for univ_shift_reg (WIDTH=8, CNT_W=4).
module tb_univ_shift_reg;

    logic       clk = 1'b0;
    logic       rst, start, serial_in_l, serial_in_r;
    logic [2:0] op;
    logic [3:0] count;
    logic [7:0] parallel_in, parallel_out;
    logic       serial_out_l, serial_out_r, busy, done;

    int vectors = 0;
    int miscompares = 0;
    int n;

    univ_shift_reg #(.WIDTH(8), .CNT_W(4)) dut (
        .clk(clk), .rst(rst), .start(start), .op(op), .count(count),
        .serial_in_l(serial_in_l), .serial_in_r(serial_in_r),
        .parallel_in(parallel_in), .parallel_out(parallel_out),
        .serial_out_l(serial_out_l), .serial_out_r(serial_out_r),
        .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
        end
    endtask

    // Inputs change and outputs are sampled 1 time unit after each rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic cmd(input logic [2:0] o, input logic [3:0] c, input logic [7:0] d);
        start = 1'b1; op = o; count = c; parallel_in = d;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_done(output int cycles);
        cycles = 0;
        while (!done && cycles < 40) begin
            tick();
            cycles++;
        end
    endtask

    initial begin
        logic [7:0] seq;
        rst = 1'b1; start = 1'b0; op = 3'b000; count = 4'd0;
        serial_in_l = 1'b0; serial_in_r = 1'b0; parallel_in = 8'h00;
        tick(); tick();
        rst = 1'b0;
        chk("rst_po", 32'(parallel_out), 32'h00);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_done", 32'(done), 0);

        // LOAD A5
        cmd(3'b001, 4'd0, 8'hA5);
        chk("load_po", 32'(parallel_out), 32'hA5);
        chk("load_done", 32'(done), 1);
        chk("load_busy", 32'(busy), 0);
        chk("load_sol", 32'(serial_out_l), 1);
        chk("load_sor", 32'(serial_out_r), 1);
        tick();
        chk("load_done_drop", 32'(done), 0);

        // LOAD 81 then ROL 3 issued back-to-back in the done cycle
        cmd(3'b001, 4'd0, 8'h81);
        cmd(3'b100, 4'd3, 8'h00);
        chk("rol3_e0_busy", 32'(busy), 1);
        chk("rol3_e0_po", 32'(parallel_out), 32'h81);
        chk("rol3_e0_done", 32'(done), 0);
        tick(); chk("rol3_s1", 32'(parallel_out), 32'h03); chk("rol3_b1", 32'(busy), 1);
        tick(); chk("rol3_s2", 32'(parallel_out), 32'h06); chk("rol3_b2", 32'(busy), 1);
        tick(); chk("rol3_s3", 32'(parallel_out), 32'h0C);
        chk("rol3_busy_end", 32'(busy), 0);
        chk("rol3_done", 32'(done), 1);
        tick(); chk("rol3_done_1cyc", 32'(done), 0);

        cmd(3'b100, 4'd8, 8'h00);
        wait_done(n);
        chk("rol8_cycles", 32'(n), 8);
        chk("rol8_po", 32'(parallel_out), 32'h0C);

        // ASR
        cmd(3'b001, 4'd0, 8'h90);
        cmd(3'b110, 4'd2, 8'h00);
        tick(); chk("asr2_s1", 32'(parallel_out), 32'hC8);
        tick(); chk("asr2_s2", 32'(parallel_out), 32'hE4);
        chk("asr2_done", 32'(done), 1);
        cmd(3'b110, 4'd15, 8'h00);
        wait_done(n);
        chk("asr15_cycles", 32'(n), 15);
        chk("asr15_po", 32'(parallel_out), 32'hFF);

        // SHL 8 with streamed serial_in_l
        seq = 8'b10110010;
        cmd(3'b010, 4'd8, 8'h00);
        for (int i = 0; i < 8; i++) begin
            serial_in_l = seq[7-i];
            tick();
        end
        chk("shl8_po", 32'(parallel_out), 32'hB2);
        chk("shl8_done", 32'(done), 1);
        serial_in_l = 1'b0;

        // SHR 4 with serial_in_r=1 from zero
        cmd(3'b001, 4'd0, 8'h00);
        serial_in_r = 1'b1;
        cmd(3'b011, 4'd4, 8'h00);
        tick(); chk("shr4_s1", 32'(parallel_out), 32'h80);
        wait_done(n);
        chk("shr4_cycles", 32'(n), 3);
        chk("shr4_po", 32'(parallel_out), 32'hF0);
        serial_in_r = 1'b0;

        // Zero-count shift and reserved op both complete immediately with no change
        cmd(3'b010, 4'd0, 8'h00);
        chk("cnt0_done", 32'(done), 1);
        chk("cnt0_busy", 32'(busy), 0);
        chk("cnt0_po", 32'(parallel_out), 32'hF0);
        cmd(3'b111, 4'd5, 8'h3C);
        chk("rsvd_done_again", 32'(done), 1);
        chk("rsvd_po", 32'(parallel_out), 32'hF0);
        tick();
        chk("rsvd_done_drop", 32'(done), 0);

        // Start while busy is ignored
        cmd(3'b011, 4'd5, 8'h00);
        tick();
        start = 1'b1; op = 3'b001; parallel_in = 8'h55; count = 4'd1;
        tick();
        start = 1'b0;
        wait_done(n);
        chk("busy_start_cycles", 32'(n + 2), 5);
        chk("busy_start_po", 32'(parallel_out), 32'h07);
        tick();
        chk("busy_start_single_done", 32'(done), 0);
        chk("busy_start_idle_po", 32'(parallel_out), 32'h07);

        // Reset mid-shift
        cmd(3'b001, 4'd0, 8'h3C);
        serial_in_l = 1'b1;
        cmd(3'b010, 4'd6, 8'h00);
        tick();
        chk("abort_s1", 32'(parallel_out), 32'h79);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("abort_po", 32'(parallel_out), 32'h00);
        chk("abort_busy", 32'(busy), 0);
        chk("abort_done", 32'(done), 0);
        tick(); tick();
        chk("abort_no_done", 32'(done), 0);
        chk("abort_hold", 32'(parallel_out), 32'h00);
        cmd(3'b001, 4'd0, 8'h5A);
        chk("post_rst_load_po", 32'(parallel_out), 32'h5A);
        chk("post_rst_load_done", 32'(done), 1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/univ_shift_reg.md
Name: univ_shift_reg

Overview:
- Parametrised universal shift register: successor to the basic n-bit serial/parallel shift register.
- Adds the following over the basic register:
  - WIDTH parameter.
  - Bidirectional logical, arithmetic and rotate shifts.
  - Multi-cycle counted shift operations, controlled by a start/busy/done handshake FSM.
- Sits between a datapath controller and serial links or bit-manipulation logic.

Parameters:
- WIDTH, 8, register width in bits; legal range ≥ 2.
- CNT_W, 4, width of the shift-count port. It must satisfy 2^CNT_W − 1 ≥ WIDTH.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  command strobe; sampled only in IDLE.
- op  input  3  operation code; captured with start.
- count  input  CNT_W  number of single-bit shifts; captured with start.
- serial_in_l  input  1  bit entering at LSB on SHL.
- serial_in_r  input  1  bit entering at MSB on SHR.
- parallel_in  input  WIDTH  load data; captured with start when op=LOAD.
- parallel_out  output  WIDTH  register contents.
- serial_out_l  output  1  combinational, equals parallel_out[WIDTH-1].
- serial_out_r  output  1  combinational, equals parallel_out[0].
- busy  output  1  high while a counted shift is in progress.
- done  output  1  single-cycle completion pulse.

Behaviour:
- Reset: when rst=1 at an edge:
  - parallel_out=0, busy=0, done=0, state=IDLE, internal count=0.
  - rst has priority over everything.
  - Reset mid-operation aborts the operation; no done pulse follows.
- Op codes:
  - 000 NOP.
  - 001 LOAD.
  - 010 SHL: {q[W-2:0], serial_in_l}.
  - 011 SHR: {serial_in_r, q[W-1:1]}.
  - 100 ROL: {q[W-2:0], q[W-1]}.
  - 101 ROR: {q[0], q[W-1:1]}.
  - 110 ASR: {q[W-1], q[W-1:1]}.
  - 111 reserved; behaves as NOP.
- FSM states: IDLE, SHIFT.
- IDLE, start=0: register holds; done=0.
- IDLE, start=1 at edge E0; op and count are latched. Then:
  - LOAD: parallel_out<=parallel_in at E0; done=1 for the cycle after E0; stay IDLE.
  - NOP or reserved: no change; done=1 for the cycle after E0; stay IDLE.
  - Shift op with count=0: no change; done=1 for the cycle after E0; stay IDLE; busy never rises.
  - Shift op with count=N≥1: go to SHIFT; remaining=N; busy=1 after E0; no data change at E0.
- SHIFT:
  - Each edge performs exactly one single-bit shift of the latched op and decrements remaining.
  - serial_in_l and serial_in_r are sampled at each shift edge, so the caller may stream a new bit every cycle.
  - At the edge where remaining goes from 1 to 0: go to IDLE; busy=0 and done=1 in the following cycle.
- Latency: for a counted shift of N, shifts occur at edges E1..EN, and done is high during the cycle after EN.
- Throughput: a new start is accepted in the cycle done is high, since the FSM is back in IDLE. Back-to-back commands lose no cycles beyond this.
- start while busy=1: ignored. No queueing, no effect on op, count or data.
- op, count and parallel_in changes while busy=1 have no effect.
- count may exceed WIDTH:
  - Logical shifts saturate to all serial-input bits.
  - Rotates wrap modulo WIDTH; ROL by WIDTH restores the original value.
  - ASR by ≥ WIDTH−1 yields all copies of the sign bit.
- done is never high for more than one consecutive cycle unless a new zero-latency command is started in that cycle. In that case done stays high for one further cycle.
- busy and done are never simultaneously high.

Test Plan:
- Reset, then LOAD with parallel_in=8'hA5 -> parallel_out=8'hA5 after E0; done=1 for exactly one cycle; busy stays 0; serial_out_l=1, serial_out_r=1.
- After LOAD 8'h81, ROL with count=3 -> busy high 3 cycles; parallel_out steps 8'h03, 8'h06, 8'h0C; done=1 in the cycle after the third shift. Then ROL with count=8 from 8'h0C -> 8'h0C.
- After LOAD 8'h90, ASR with count=2 -> 8'hC8, then 8'hE4. Then ASR with count=15 -> 8'hFF.
- SHL with count=8, serial_in_l driving the sequence 1,0,1,1,0,0,1,0 on successive cycles -> parallel_out=8'hB2. In parallel, SHR with count=4 and serial_in_r=1 from 8'h00 -> 8'hF0.
- Start pulsed again while busy (SHR with count=5; a second start with op=LOAD at cycle 2) -> second command ignored; exactly 5 shifts; a single done.
- rst asserted at the 2nd shift of a count=6 SHL -> parallel_out=0 and busy=0 next cycle, no done pulse. A following LOAD is accepted normally.
